// File: rtl/hyperbus_pkg.sv
// Shared HyperBus front-end definitions: splitter state encoding and the
// default burst/boundary limits also used by the AXI-side front-end.
package hyperbus_pkg;

  localparam int unsigned HB_MAX_BURST      = 256;
  localparam int unsigned HB_BOUNDARY_WORDS = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } splitter_state_t;

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// Size of the next PHY transaction: the smallest of the words still owed,
// the maximum burst, and the room left before the next aligned boundary.
module hyperbus_chunk_calc
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH    = 12,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BURST      = HB_MAX_BURST,
  parameter int unsigned BOUNDARY_WORDS = HB_BOUNDARY_WORDS
) (
  input  logic [31:0]            addr_i,
  input  logic [LEN_WIDTH-1:0]   remaining_i,
  output logic [BURST_WIDTH-1:0] chunk_o
);

  // One bit wider than either operand so the boundary room never wraps.
  localparam int unsigned CW = ((LEN_WIDTH > 32) ? LEN_WIDTH : 32) + 1;

  logic [CW-1:0] rem_ext;
  logic [CW-1:0] room;
  logic [CW-1:0] cap;
  logic [CW-1:0] lim;

  always_comb begin
    rem_ext = CW'(remaining_i);
    room    = CW'(BOUNDARY_WORDS) - CW'(addr_i & 32'(BOUNDARY_WORDS - 1));
    cap     = (room < CW'(MAX_BURST)) ? room : CW'(MAX_BURST);
    lim     = (rem_ext < cap) ? rem_ext : cap;
    chunk_o = BURST_WIDTH'(lim);
  end

endmodule

// File: rtl/hyperbus_trans_splitter.sv
// Splits one linear memory request into bounded, boundary-safe PHY
// transactions and gates the tx/rx beat streams to each transaction.
module hyperbus_trans_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned BURST_WIDTH    = 12,
  parameter int unsigned NR_CS          = 2,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BURST      = HB_MAX_BURST,
  parameter int unsigned BOUNDARY_WORDS = HB_BOUNDARY_WORDS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_addr_i,
  input  logic [LEN_WIDTH-1:0]   req_len_i,
  input  logic                   req_write_i,
  input  logic [NR_CS-1:0]       req_cs_i,
  output logic                   done_o,
  output logic                   trans_valid_o,
  input  logic                   trans_ready_i,
  output logic [31:0]            trans_address_o,
  output logic [NR_CS-1:0]       trans_cs_o,
  output logic                   trans_write_o,
  output logic [BURST_WIDTH-1:0] trans_burst_o,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [15:0]            tx_data_i,
  input  logic [1:0]             tx_strb_i,
  output logic                   phy_tx_valid_o,
  input  logic                   phy_tx_ready_i,
  output logic [15:0]            phy_tx_data_o,
  output logic [1:0]             phy_tx_strb_o,
  input  logic                   phy_rx_valid_i,
  output logic                   phy_rx_ready_o,
  input  logic [15:0]            phy_rx_data_i,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [15:0]            rx_data_o,
  output splitter_state_t        dbg_state_o
);

  // Handshake semantics on every channel: a transfer happens in a cycle where
  // valid and ready are both high; valid never depends on ready.

  splitter_state_t        state_q, state_d;
  logic [31:0]            cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;
  logic                   write_q, write_d;
  logic [NR_CS-1:0]       cs_q, cs_d;

  logic [BURST_WIDTH-1:0] chunk;
  logic                   data_wr;
  logic                   data_rd;
  logic                   beat;

  hyperbus_chunk_calc #(
    .BURST_WIDTH    (BURST_WIDTH),
    .LEN_WIDTH      (LEN_WIDTH),
    .MAX_BURST      (MAX_BURST),
    .BOUNDARY_WORDS (BOUNDARY_WORDS)
  ) u_chunk_calc (
    .addr_i      (cur_addr_q),
    .remaining_i (remaining_q),
    .chunk_o     (chunk)
  );

  assign data_wr = (state_q == ST_DATA) &  write_q;
  assign data_rd = (state_q == ST_DATA) & ~write_q;
  assign beat    = data_wr ? (tx_valid_i & phy_tx_ready_i)
                           : (data_rd & phy_rx_valid_i & rx_ready_i);

  assign req_ready_o     = (state_q == ST_IDLE);
  assign trans_valid_o   = (state_q == ST_ISSUE);
  assign done_o          = (state_q == ST_DONE);
  assign trans_address_o = cur_addr_q;
  assign trans_cs_o      = cs_q;
  assign trans_write_o   = write_q;
  assign trans_burst_o   = chunk;
  assign dbg_state_o     = state_q;

  // Zero-latency data paths; only the handshake bits are gated.
  assign phy_tx_valid_o = data_wr & tx_valid_i;
  assign tx_ready_o     = data_wr & phy_tx_ready_i;
  assign phy_tx_data_o  = tx_data_i;
  assign phy_tx_strb_o  = tx_strb_i;
  assign rx_valid_o     = data_rd & phy_rx_valid_i;
  assign phy_rx_ready_o = data_rd & rx_ready_i;
  assign rx_data_o      = phy_rx_data_i;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    write_d     = write_q;
    cs_d        = cs_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          cur_addr_d  = req_addr_i >> 1;
          remaining_d = req_len_i;
          write_d     = req_write_i;
          cs_d        = req_cs_i;
          state_d     = (req_len_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (trans_ready_i) begin
          beats_d     = chunk;
          cur_addr_d  = cur_addr_q + 32'(chunk);
          remaining_d = remaining_q - LEN_WIDTH'(chunk);
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          beats_d = beats_q - BURST_WIDTH'(1);
          if (beats_q == BURST_WIDTH'(1)) begin
            state_d = (remaining_q != '0) ? ST_ISSUE : ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      write_q     <= 1'b0;
      cs_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      write_q     <= write_d;
      cs_q        <= cs_d;
    end
  end

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// Randomized bench for hyperbus_trans_splitter: a request runner records the
// PHY-side view, and each scenario task compares it to an arithmetic model.
module tb_hyperbus_trans_splitter;
  import hyperbus_pkg::*;

  localparam int BW   = 12;
  localparam int NCS  = 2;
  localparam int LW   = 16;
  localparam int MAXB = 256;
  localparam int BND  = 512;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic req_write_i = 1'b0;
  logic [NCS-1:0] req_cs_i = '0;
  logic done_o, trans_valid_o;
  logic trans_ready_i = 1'b0;
  logic [31:0] trans_address_o;
  logic [NCS-1:0] trans_cs_o;
  logic trans_write_o;
  logic [BW-1:0] trans_burst_o;
  logic tx_valid_i = 1'b0, tx_ready_o;
  logic [15:0] tx_data_i = '0;
  logic [1:0] tx_strb_i = '0;
  logic phy_tx_valid_o;
  logic phy_tx_ready_i = 1'b0;
  logic [15:0] phy_tx_data_o;
  logic [1:0] phy_tx_strb_o;
  logic phy_rx_valid_i = 1'b0, phy_rx_ready_o;
  logic [15:0] phy_rx_data_i = '0;
  logic rx_valid_o;
  logic rx_ready_i = 1'b0;
  logic [15:0] rx_data_o;
  splitter_state_t dbg_state_o;

  hyperbus_trans_splitter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_write_i(req_write_i), .req_cs_i(req_cs_i), .done_o(done_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
    .trans_address_o(trans_address_o), .trans_cs_o(trans_cs_o),
    .trans_write_o(trans_write_o), .trans_burst_o(trans_burst_o),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_data_i(tx_data_i), .tx_strb_i(tx_strb_i),
    .phy_tx_valid_o(phy_tx_valid_o), .phy_tx_ready_i(phy_tx_ready_i),
    .phy_tx_data_o(phy_tx_data_o), .phy_tx_strb_o(phy_tx_strb_o),
    .phy_rx_valid_i(phy_rx_valid_i), .phy_rx_ready_o(phy_rx_ready_o),
    .phy_rx_data_i(phy_rx_data_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---- clock / cycle counter ----
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---- reference model: expected transaction list ----
  logic [31:0]   exp_addr_q[$];
  logic [BW-1:0] exp_burst_q[$];

  function automatic void build_exp(input logic [31:0] addr, input int len);
    longint cur = longint'(addr >> 1);
    int rem = len;
    int c;
    exp_addr_q.delete();
    exp_burst_q.delete();
    while (rem > 0) begin
      c = rem;
      if (c > MAXB) c = MAXB;
      if (c > BND - int'(cur % BND)) c = BND - int'(cur % BND);
      exp_addr_q.push_back(32'(cur));
      exp_burst_q.push_back(BW'(c));
      cur += c;
      rem -= c;
    end
  endfunction

  // ---- observations recorded by the runner ----
  logic [31:0]    obs_addr_q[$];
  logic [BW-1:0]  obs_burst_q[$];
  logic [NCS-1:0] obs_cs_q[$];
  logic           obs_wr_q[$];
  int obs_prior_q[$];
  int obs_gap_q[$];
  int beats, gate_err, pass_err, stable_err, timeout;
  int accept_cyc, done_cyc, last_beat_cyc, done_seen;
  logic ready_at_done;

  // Drives one request and the PHY/upstream sides until done_o or budget.
  task automatic run_req(input logic [31:0] addr, input int len, input bit wr,
                         input logic [NCS-1:0] cs, input bit bp, input int stall);
    int burst_sum = 0;
    int stall_cnt = 0;
    int prev_evt;
    bit tv_prev = 0;
    bit gate_open;
    logic [31:0] s_addr;
    logic [BW-1:0] s_burst;
    logic [NCS-1:0] s_cs;
    obs_addr_q.delete(); obs_burst_q.delete(); obs_cs_q.delete();
    obs_wr_q.delete(); obs_prior_q.delete(); obs_gap_q.delete();
    beats = 0; gate_err = 0; pass_err = 0; stable_err = 0; timeout = 0;
    done_seen = 0; done_cyc = 0; last_beat_cyc = 0; ready_at_done = 1'b1;
    s_addr = '0; s_burst = '0; s_cs = '0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = addr; req_len_i = LW'(len);
    req_write_i = wr; req_cs_i = cs;
    #1;
    accept_cyc = cyc;
    prev_evt = cyc;
    for (int n = 0; n < 5000 && done_seen == 0; n++) begin
      @(negedge clk_i);
      req_valid_i    = 1'b0;
      trans_ready_i  = (stall_cnt >= stall) && (!bp || $urandom_range(0, 1) == 1);
      tx_valid_i     = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tx_data_i      = 16'($urandom);
      tx_strb_i      = 2'($urandom);
      phy_tx_ready_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      phy_rx_valid_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      phy_rx_data_i  = 16'($urandom);
      rx_ready_i     = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      gate_open = burst_sum > beats;
      if (trans_valid_o) begin
        if (!tv_prev) begin
          obs_gap_q.push_back(cyc - prev_evt);
          s_addr = trans_address_o; s_burst = trans_burst_o; s_cs = trans_cs_o;
        end else if (trans_address_o !== s_addr || trans_burst_o !== s_burst ||
                     trans_cs_o !== s_cs) begin
          stable_err++;
        end
        if (trans_ready_i) begin
          obs_addr_q.push_back(trans_address_o);
          obs_burst_q.push_back(trans_burst_o);
          obs_cs_q.push_back(trans_cs_o);
          obs_wr_q.push_back(trans_write_o);
          obs_prior_q.push_back(beats);
          burst_sum += int'(trans_burst_o);
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end
      tv_prev = trans_valid_o && !trans_ready_i;
      if (!gate_open) begin
        if (tx_ready_o || phy_tx_valid_o || rx_valid_o || phy_rx_ready_o) gate_err++;
      end else if (wr) begin
        if (phy_tx_valid_o !== tx_valid_i || tx_ready_o !== phy_tx_ready_i ||
            rx_valid_o || phy_rx_ready_o) gate_err++;
        if (phy_tx_data_o !== tx_data_i || phy_tx_strb_o !== tx_strb_i) pass_err++;
        if (tx_valid_i && phy_tx_ready_i) begin
          beats++; last_beat_cyc = cyc;
          if (beats == burst_sum) prev_evt = cyc;
        end
      end else begin
        if (rx_valid_o !== phy_rx_valid_i || phy_rx_ready_o !== rx_ready_i ||
            tx_ready_o || phy_tx_valid_o) gate_err++;
        if (rx_data_o !== phy_rx_data_i) pass_err++;
        if (phy_rx_valid_i && rx_ready_i) begin
          beats++; last_beat_cyc = cyc;
          if (beats == burst_sum) prev_evt = cyc;
        end
      end
      if (done_o) begin
        done_seen = 1; done_cyc = cyc; ready_at_done = req_ready_o;
      end
    end
    if (done_seen == 0) timeout = 1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_i = 1'b1;
    tx_valid_i = 1'b1; phy_tx_ready_i = 1'b1; phy_rx_valid_i = 1'b1; rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    total++;
    if (req_ready_o !== 1'b1 || trans_valid_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b tvalid=%b done=%b exp 1/0/0", req_ready_o, trans_valid_o, done_o);
    end
    total++;
    if ({tx_ready_o, phy_tx_valid_o, rx_valid_o, phy_rx_ready_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gate: got %b exp 0000",
               {tx_ready_o, phy_tx_valid_o, rx_valid_o, phy_rx_ready_o});
    end
    total++;
    if (dbg_state_o !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d exp %0d", dbg_state_o, ST_IDLE);
    end
  endtask

  task automatic test_single_read();
    build_exp(32'h100, 16);
    run_req(32'h100, 16, 1'b0, 2'b01, 1'b0, 0);
    total++;
    if (obs_addr_q.size() != 1 || obs_addr_q[0] !== exp_addr_q[0] ||
        obs_burst_q[0] !== exp_burst_q[0] || obs_cs_q[0] !== 2'b01 || obs_wr_q[0] !== 1'b0) begin
      bad++; $display("FAIL single_trans: n=%0d exp addr=%0h burst=%0d", obs_addr_q.size(),
                      exp_addr_q[0], exp_burst_q[0]);
    end
    total++;
    if (beats != 16 || gate_err != 0 || pass_err != 0) begin
      bad++; $display("FAIL single_beats: beats=%0d gate=%0d pass=%0d exp 16/0/0", beats, gate_err, pass_err);
    end
    total++;
    if (timeout != 0 || done_cyc - last_beat_cyc != 1 || obs_gap_q.size() != 1 || obs_gap_q[0] != 1) begin
      bad++; $display("FAIL single_timing: to=%0d done_lat=%0d exp 0/1", timeout, done_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_boundary_write();
    int exp_prior = 0;
    build_exp(32'h3E0, 64);
    run_req(32'h3E0, 64, 1'b1, 2'b10, 1'b0, 0);
    total++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL bnd_count: got %0d exp %0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      total++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_burst_q[i] !== exp_burst_q[i] ||
          obs_prior_q[i] != exp_prior || obs_gap_q[i] != 1 || obs_wr_q[i] !== 1'b1) begin
        bad++;
        $display("FAIL bnd_trans%0d: addr=%0h burst=%0d prior=%0d gap=%0d exp %0h/%0d/%0d/1", i,
                 obs_addr_q[i], obs_burst_q[i], obs_prior_q[i], obs_gap_q[i],
                 exp_addr_q[i], exp_burst_q[i], exp_prior);
      end
      exp_prior += int'(exp_burst_q[i]);
    end
    total++;
    if (beats != 64 || gate_err != 0 || pass_err != 0 || timeout != 0 || done_cyc - last_beat_cyc != 1) begin
      bad++; $display("FAIL bnd_beats: beats=%0d gate=%0d pass=%0d to=%0d exp 64/0/0/0",
                      beats, gate_err, pass_err, timeout);
    end
  endtask

  task automatic test_long_read();
    int mism = 0;
    build_exp(32'h0, 600);
    run_req(32'h0, 600, 1'b0, 2'b01, 1'b1, 0);
    for (int i = 0; i < exp_addr_q.size(); i++)
      if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i] || obs_burst_q[i] !== exp_burst_q[i]) mism++;
    total++;
    if (mism != 0 || obs_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL long_trans: mism=%0d n=%0d exp n=%0d", mism, obs_addr_q.size(), exp_addr_q.size());
    end
    total++;
    if (beats != 600 || gate_err != 0 || pass_err != 0 || timeout != 0) begin
      bad++; $display("FAIL long_beats: beats=%0d gate=%0d pass=%0d to=%0d exp 600/0/0/0",
                      beats, gate_err, pass_err, timeout);
    end
  endtask

  task automatic test_trans_backpressure();
    int mism = 0;
    build_exp(32'h3E0, 64);
    run_req(32'h3E0, 64, 1'b1, 2'b01, 1'b1, 5);
    for (int i = 0; i < exp_addr_q.size(); i++)
      if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i] || obs_burst_q[i] !== exp_burst_q[i]) mism++;
    total++;
    if (stable_err != 0 || mism != 0 || obs_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL bp_stable: unstable=%0d mism=%0d exp 0/0", stable_err, mism);
    end
    total++;
    if (beats != 64 || gate_err != 0 || timeout != 0) begin
      bad++; $display("FAIL bp_beats: beats=%0d gate=%0d to=%0d exp 64/0/0", beats, gate_err, timeout);
    end
  endtask

  task automatic test_zero_len();
    run_req(32'h10, 0, 1'b1, 2'b01, 1'b0, 0);
    total++;
    if (obs_addr_q.size() != 0 || beats != 0 || timeout != 0 || done_cyc - accept_cyc != 1 || ready_at_done !== 1'b0) begin
      bad++; $display("FAIL zero_len: n=%0d beats=%0d to=%0d lat=%0d rdy=%b exp 0/0/0/1/0",
                      obs_addr_q.size(), beats, timeout, done_cyc - accept_cyc, ready_at_done);
    end
    @(negedge clk_i); #1;
    total++;
    if (done_o !== 1'b0 || req_ready_o !== 1'b1 || trans_valid_o !== 1'b0) begin
      bad++; $display("FAIL zero_after: done=%b ready=%b tvalid=%b exp 0/1/0", done_o, req_ready_o, trans_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h400; req_len_i = LW'(16);
    req_write_i = 1'b1; req_cs_i = 2'b01;
    for (int n = 0; n < 100 && cnt < 3; n++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; trans_ready_i = 1'b1; tx_valid_i = 1'b1; phy_tx_ready_i = 1'b1;
      #1;
      if (phy_tx_valid_o && phy_tx_ready_i) cnt++;
    end
    total++;
    if (cnt != 3) begin
      bad++; $display("FAIL rstmid_beats: got %0d exp 3", cnt);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    total++;
    if (dbg_state_o !== ST_IDLE || trans_valid_o !== 1'b0 || done_o !== 1'b0 ||
        {tx_ready_o, phy_tx_valid_o, rx_valid_o, phy_rx_ready_o} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_idle: state=%0d tvalid=%b done=%b ptxv=%b exp 0/0/0/0",
                      dbg_state_o, trans_valid_o, done_o, phy_tx_valid_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    total++;
    if (req_ready_o !== 1'b1 || phy_tx_valid_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_ready: ready=%b ptxv=%b exp 1/0", req_ready_o, phy_tx_valid_o);
    end
    build_exp(32'h400, 16);
    run_req(32'h400, 16, 1'b1, 2'b10, 1'b0, 0);
    total++;
    if (obs_addr_q.size() != 1 || obs_addr_q[0] !== exp_addr_q[0] || obs_burst_q[0] !== exp_burst_q[0] ||
        beats != 16 || timeout != 0 || done_cyc - last_beat_cyc != 1) begin
      bad++; $display("FAIL rstmid_rerun: n=%0d beats=%0d to=%0d exp 1/16/0", obs_addr_q.size(), beats, timeout);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int r = 0; r < 12; r++) begin
      logic [31:0] a;
      int len;
      bit wr;
      logic [NCS-1:0] cs;
      int err = 0;
      a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
      len = $urandom_range(0, 300);
      wr = $urandom_range(0, 1) == 1;
      cs = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      build_exp(a, len);
      run_req(a, len, wr, cs, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
      if (obs_addr_q.size() != exp_addr_q.size()) err++;
      for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++)
        if (obs_addr_q[i] !== exp_addr_q[i] || obs_burst_q[i] !== exp_burst_q[i] ||
            obs_cs_q[i] !== cs || obs_wr_q[i] !== wr) err++;
      if (beats != len) err++;
      if (len > 0 && done_cyc - last_beat_cyc != 1) err++;
      if (len == 0 && done_cyc - accept_cyc != 1) err++;
      err += gate_err + pass_err + stable_err + timeout;
      total++;
      if (err != 0) begin
        bad++;
        $display("FAIL rand%0d: addr=%0h len=%0d wr=%b errs=%0d beats=%0d n=%0d exp n=%0d",
                 r, a, len, wr, err, beats, obs_addr_q.size(), exp_addr_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_boundary_write();
    test_long_read();
    test_trans_backpressure();
    test_zero_len();
    test_reset_mid();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
